// File: rtl/seg_scan_if.sv
// Bus between a display controller and the seven-segment scan driver.
// Master: load/value/blank_lz out; slave: digit/an/slot_tick out.
interface seg_scan_if #(
  parameter int NDIG = 8
);
  logic              load;
  logic [4*NDIG-1:0] value;
  logic              blank_lz;
  logic [3:0]        digit;
  logic [NDIG-1:0]   an;
  logic              slot_tick;

  modport master (
    output load, value, blank_lz,
    input  digit, an, slot_tick
  );

  modport slave (
    input  load, value, blank_lz,
    output digit, an, slot_tick
  );
endinterface

// File: rtl/seg_scan.sv
// Scan driver for a common-anode multi-digit seven-segment display.
// Ports: clk, rst (sync, high); bus (slave): load/value/blank_lz in,
// digit (nibble), an (active-low select), slot_tick out.
module seg_scan #(
  parameter int NDIG  = 8,
  parameter int DIV   = 50000,
  parameter int GUARD = 0
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int IW = $clog2(NDIG);
  localparam int CW = $clog2(DIV);

  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        digit_q, digit_d;
  logic [NDIG-1:0]   sel_q, sel_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              tick_q, tick_d;

  logic [NDIG-1:0]   blank_v;
  logic              allz;
  logic              wrap;
  logic              dark;

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    allz    = 1'b1;
    blank_v = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      allz       = allz & (shadow_q[4*i +: 4] == 4'd0);
      blank_v[i] = bus.blank_lz && (i != 0) && allz;
    end
  end

  if (GUARD == 0) begin : g_noguard
    assign dark = 1'b0;
  end else begin : g_guard
    assign dark = (cnt_q < CW'(GUARD));
  end

  assign wrap = (cnt_q == CW'(DIV - 1));

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (bus.load) shadow_d = bus.value;
    if (wrap) begin
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
    digit_d = blank_v[idx_q] ? 4'd0 : shadow_q[4*idx_q +: 4];
    sel_d   = (blank_v[idx_q] || dark) ? '1
            : ~(NDIG'(1) << idx_q);
    // Extra stage lines the select up with the decoder register.
    an_d    = sel_q;
    tick_d  = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      digit_q  <= '0;
      sel_q    <= '1;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      digit_q  <= digit_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.digit     = digit_q;
  assign bus.an        = an_q;
  assign bus.slot_tick = tick_q;
endmodule
